// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state type and counter sizing for the iterative multiply/divide engine.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  localparam int unsigned MD_DEF_WIDTH = 32;

  function automatic int unsigned md_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  localparam int unsigned MD_CNT_W = md_cnt_width(MD_DEF_WIDTH);

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: used for operand magnitudes and signed result fix-up.
module muldiv_signfix #(
  parameter int unsigned W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  assign data_o = neg_i ? ('0 - data_i) : data_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine returning {hi,lo}; one bit per cycle on magnitudes.
// Optional MULDIV_FAST_MUL_EN replaces the shift-add multiply with a one-cycle multiplier.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int unsigned WIDTH = MD_DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 divzero_o
);

  localparam int unsigned CNT_W = md_cnt_width(WIDTH);

  md_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 divzero_q, divzero_d;

  logic                 op_signed;
  logic [WIDTH-1:0]     abs_a, abs_b;

  assign op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);

  muldiv_signfix #(.W(WIDTH)) u_abs_a (
    .neg_i  (op_signed & opdata1_i[WIDTH-1]),
    .data_i (opdata1_i),
    .data_o (abs_a)
  );

  muldiv_signfix #(.W(WIDTH)) u_abs_b (
    .neg_i  (op_signed & opdata2_i[WIDTH-1]),
    .data_i (opdata2_i),
    .data_o (abs_b)
  );

  // Multiply: hi_q accumulates, lo_q holds the multiplier shifting out LSB-first.
  logic [WIDTH-1:0]     mul_hi_n, mul_lo_n;
  logic                 mul_last;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0]   fast_prod;

  assign fast_prod            = {{WIDTH{1'b0}}, lo_q} * {{WIDTH{1'b0}}, opb_q};
  assign {mul_hi_n, mul_lo_n} = fast_prod;
  assign mul_last             = 1'b1;
`else
  logic [WIDTH:0]       mul_sum;

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
  assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  // Restoring divide: hi_q is the partial remainder, lo_q shifts dividend out / quotient in.
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_trial, div_rem_n, div_quo_n;
  logic                 div_last;

  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_trial = div_shift[WIDTH-1:0] - opb_q;
  assign div_rem_n = div_ge ? div_trial : div_shift[WIDTH-1:0];
  assign div_quo_n = {lo_q[WIDTH-2:0], div_ge};
  assign div_last  = (cnt_q == CNT_W'(WIDTH - 1));

  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
    .neg_i  (neg_q),
    .data_i ({mul_hi_n, mul_lo_n}),
    .data_o (prod_fix)
  );

  muldiv_signfix #(.W(WIDTH)) u_fix_quo (
    .neg_i  (neg_q),
    .data_i (div_quo_n),
    .data_o (quo_fix)
  );

  muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .neg_i  (rneg_q),
    .data_i (div_rem_n),
    .data_o (rem_fix)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;
    ready_d   = 1'b0;
    divzero_d = divzero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !annul_i) begin
          hi_d   = '0;
          lo_d   = abs_a;
          opb_d  = abs_b;
          cnt_d  = '0;
          neg_d  = op_signed & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          rneg_d = op_signed & opdata1_i[WIDTH-1];
          if (!op_i[1]) begin
            state_d = ST_MUL;
          end else if (opdata2_i == '0) begin
            // Zero divisor bypasses sign fix-up so the raw dividend is returned as-is.
            state_d   = ST_DONE;
            ready_d   = 1'b1;
            divzero_d = 1'b1;
            result_d  = {opdata1_i, {WIDTH{1'b1}}};
          end else begin
            state_d = ST_DIV;
          end
        end
      end

      ST_MUL: begin
        if (annul_i) begin
          state_d = ST_IDLE;
        end else begin
          hi_d  = mul_hi_n;
          lo_d  = mul_lo_n;
          cnt_d = cnt_q + 1'b1;
          if (mul_last) begin
            state_d   = ST_DONE;
            ready_d   = 1'b1;
            divzero_d = 1'b0;
            result_d  = prod_fix;
          end
        end
      end

      ST_DIV: begin
        if (annul_i) begin
          state_d = ST_IDLE;
        end else begin
          hi_d  = div_rem_n;
          lo_d  = div_quo_n;
          cnt_d = cnt_q + 1'b1;
          if (div_last) begin
            state_d   = ST_DONE;
            ready_d   = 1'b1;
            divzero_d = 1'b0;
            result_d  = {rem_fix, quo_fix};
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      divzero_q <= divzero_d;
    end
  end

  assign result_o  = result_q;
  assign ready_o   = ready_q;
  assign divzero_o = divzero_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule
